// File: rtl/mvu_jobctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mvu_jobctrl_if
// Purpose  : Job configuration, bank-read and strobe bundle between a job
//            source / bank fabric and one mvu_jobctrl instance.
// Ports    : (interface signals)
//   start, countdown, wbaseaddr, ibaseaddr, wstride_0, istride_0,
//   wlength_0, ilength_0, rdd_grnt            -> into the job controller
//   rdw_addr, rdd_en, rdd_addr, acc_clr, acc_sh,
//   quant_clr, quant_start, busy, done        -> out of the job controller
// Modports : master (job source / fabric side), slave (mvu_jobctrl side)
// Revision : 1.0  initial release
// ============================================================================
interface mvu_jobctrl_if #(
  parameter int BWBANKA = 9,
  parameter int BDBANKA = 15,
  parameter int BCNTDWN = 29
);
  logic               start;
  logic [BCNTDWN-1:0] countdown;
  logic [31:0]        wbaseaddr;
  logic [31:0]        ibaseaddr;
  logic [31:0]        wstride_0;
  logic [31:0]        istride_0;
  logic [31:0]        wlength_0;
  logic [31:0]        ilength_0;
  logic               rdd_grnt;

  logic [BWBANKA-1:0] rdw_addr;
  logic               rdd_en;
  logic [BDBANKA-1:0] rdd_addr;
  logic               acc_clr;
  logic               acc_sh;
  logic               quant_clr;
  logic               quant_start;
  logic               busy;
  logic               done;

  modport master (
    output start, countdown, wbaseaddr, ibaseaddr, wstride_0, istride_0,
           wlength_0, ilength_0, rdd_grnt,
    input  rdw_addr, rdd_en, rdd_addr, acc_clr, acc_sh, quant_clr,
           quant_start, busy, done
  );

  modport slave (
    input  start, countdown, wbaseaddr, ibaseaddr, wstride_0, istride_0,
           wlength_0, ilength_0, rdd_grnt,
    output rdw_addr, rdd_en, rdd_addr, acc_clr, acc_sh, quant_clr,
           quant_start, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mvu_jobctrl.sv
`default_nettype none
// ============================================================================
// Module   : mvu_jobctrl
// Purpose  : Per-MVU job sequencer. Latches one job configuration, walks the
//            weight/data bank read addresses with a two-level stride/length
//            walker, honours the data-bank grant and emits accumulator and
//            quantizer strobes aligned to the bank read latency.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mvu_jobctrl_if.slave (config in, addresses/strobes out)
// Revision : 1.0  initial release
// ============================================================================
module mvu_jobctrl #(
  parameter int BWBANKA = 9,
  parameter int BDBANKA = 15,
  parameter int BCNTDWN = 29,
  parameter int RDLAT   = 1,   // 1..4
  parameter int PIPE    = 3    // 1..15
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mvu_jobctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // DRAIN lasts RDLAT cycles for the delay line to empty plus PIPE cycles of
  // datapath drain; done/quant_start are registered one cycle early so they
  // are high during the last DRAIN cycle and fall together with busy.
  localparam logic [4:0] c_DRAIN_LAST = 5'(RDLAT + PIPE - 1);

  state_t             r_state, w_state_nxt;
  logic               r_rdd_en, w_rdd_en_nxt;
  logic               r_qclr, w_qclr_nxt;
  logic               r_qstart, w_qstart_nxt;
  logic               r_done, w_done_nxt;
  logic [4:0]         r_dcnt, w_dcnt_nxt;
  logic               w_latch;
  logic               w_issue;
  logic               w_push_clr;
  logic               w_push_sh;

  // latched job configuration
  logic [BWBANKA-1:0] r_wbase, r_wstride;
  logic [BDBANKA-1:0] r_ibase, r_istride;
  logic [31:0]        r_wlen, r_ilen;

  // walker state
  logic [BWBANKA-1:0] r_waddr;
  logic [BDBANKA-1:0] r_iaddr;
  logic [31:0]        r_wcnt, r_icnt;
  logic [BCNTDWN-1:0] r_remain;
  logic               r_first;

  // strobe delay lines, bit 0 is the newest entry
  logic [RDLAT-1:0]   r_dl_clr, r_dl_sh;

  assign w_issue = r_rdd_en & bus.rdd_grnt;

  // --------------------------------------------------------------------------
  // FSM state / registered control outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rdd_en <= 1'b0;
      r_qclr   <= 1'b0;
      r_qstart <= 1'b0;
      r_done   <= 1'b0;
      r_dcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdd_en <= w_rdd_en_nxt;
      r_qclr   <= w_qclr_nxt;
      r_qstart <= w_qstart_nxt;
      r_done   <= w_done_nxt;
      r_dcnt   <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rdd_en_nxt = r_rdd_en;
    w_qclr_nxt   = 1'b0;
    w_qstart_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_dcnt_nxt   = r_dcnt;
    w_latch      = 1'b0;
    w_push_clr   = 1'b0;
    w_push_sh    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_latch = 1'b1;
          if (bus.countdown == '0) begin
            // empty job: complete immediately, never touch the banks
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_RUN;
            w_rdd_en_nxt = 1'b1;
            w_qclr_nxt   = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (w_issue) begin
          w_push_clr = r_first;
          w_push_sh  = (r_wcnt == '0) && !r_first;
          if (r_remain == BCNTDWN'(1)) begin
            w_state_nxt  = S_DRAIN;
            w_rdd_en_nxt = 1'b0;
            w_dcnt_nxt   = '0;
          end
        end
      end

      S_DRAIN: begin
        if (r_dcnt == c_DRAIN_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dcnt_nxt = r_dcnt + 5'd1;
          if (r_dcnt + 5'd1 == c_DRAIN_LAST) begin
            w_done_nxt   = 1'b1;
            w_qstart_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_rdd_en_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration latch, two-level address walker, strobe delay lines
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbase   <= '0;
      r_wstride <= '0;
      r_ibase   <= '0;
      r_istride <= '0;
      r_wlen    <= '0;
      r_ilen    <= '0;
      r_waddr   <= '0;
      r_iaddr   <= '0;
      r_wcnt    <= '0;
      r_icnt    <= '0;
      r_remain  <= '0;
      r_first   <= 1'b0;
      r_dl_clr  <= '0;
      r_dl_sh   <= '0;
    end else begin
      // every cycle shifts; non-issue cycles push zeros
      r_dl_clr[0] <= w_push_clr;
      r_dl_sh[0]  <= w_push_sh;
      for (int i = 1; i < RDLAT; i++) begin
        r_dl_clr[i] <= r_dl_clr[i-1];
        r_dl_sh[i]  <= r_dl_sh[i-1];
      end

      if (w_latch) begin
        r_wbase   <= bus.wbaseaddr[BWBANKA-1:0];
        r_wstride <= bus.wstride_0[BWBANKA-1:0];
        r_ibase   <= bus.ibaseaddr[BDBANKA-1:0];
        r_istride <= bus.istride_0[BDBANKA-1:0];
        r_wlen    <= bus.wlength_0;
        r_ilen    <= bus.ilength_0;
        r_waddr   <= bus.wbaseaddr[BWBANKA-1:0];
        r_iaddr   <= bus.ibaseaddr[BDBANKA-1:0];
        r_wcnt    <= '0;
        r_icnt    <= '0;
        r_remain  <= bus.countdown;
        r_first   <= 1'b1;
      end else if (w_issue) begin
        r_remain <= r_remain - BCNTDWN'(1);
        r_first  <= 1'b0;
        if (r_wcnt == r_wlen) begin
          // inner wrap steps the outer walker in the same edge
          r_wcnt  <= '0;
          r_waddr <= r_wbase;
          if (r_icnt == r_ilen) begin
            r_icnt  <= '0;
            r_iaddr <= r_ibase;
          end else begin
            r_icnt  <= r_icnt + 32'd1;
            r_iaddr <= r_iaddr + r_istride;
          end
        end else begin
          r_wcnt  <= r_wcnt + 32'd1;
          r_waddr <= r_waddr + r_wstride;
        end
      end
    end
  end

  assign bus.rdw_addr    = r_waddr;
  assign bus.rdd_addr    = r_iaddr;
  assign bus.rdd_en      = r_rdd_en;
  assign bus.acc_clr     = r_dl_clr[RDLAT-1];
  assign bus.acc_sh      = r_dl_sh[RDLAT-1];
  assign bus.quant_clr   = r_qclr;
  assign bus.quant_start = r_qstart;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mvu_jobctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_jobctrl
// Purpose  : Self-checking bench for mvu_jobctrl. Stimulus pushes expected
//            issue addresses and strobe events (kind + cycle) into queues; a
//            negedge monitor pops and compares whenever the DUT presents an
//            issue or a strobe.
// Revision : 1.0  initial release
// ============================================================================
module tb_mvu_jobctrl;
  localparam int BWBANKA = 9;
  localparam int BDBANKA = 15;
  localparam int BCNTDWN = 29;
  localparam int RDLAT   = 1;
  localparam int PIPE    = 3;

  // event kinds
  localparam int E_QCLR = 0, E_ACLR = 1, E_ASH = 2, E_QSTART = 3, E_DONE = 4;

  typedef struct { int w; int d; }      addr_t;
  typedef struct { int kind; int cyc; } ev_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc      = 0;
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  addr_t addr_q[$];
  ev_t   ev_q[$];
  addr_t mon_a;

  mvu_jobctrl_if #(.BWBANKA(BWBANKA), .BDBANKA(BDBANKA), .BCNTDWN(BCNTDWN)) bus();

  mvu_jobctrl #(
    .BWBANKA(BWBANKA), .BDBANKA(BDBANKA), .BCNTDWN(BCNTDWN),
    .RDLAT(RDLAT), .PIPE(PIPE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take_ev(input int kind);
    ev_t e;
    if (ev_q.size() == 0) begin
      check($sformatf("unexpected_event_kind%0d", kind), cyc, -1);
    end else begin
      e = ev_q.pop_front();
      check($sformatf("event_kind%0d", kind), kind, e.kind);
      check($sformatf("event_cycle_kind%0d", kind), cyc, e.cyc);
    end
  endtask

  // monitor: compare on every issue and every strobe
  always @(negedge clk) begin
    if (bus.rdd_en && bus.rdd_grnt) begin
      if (addr_q.size() == 0) begin
        check("unexpected_issue", cyc, -1);
      end else begin
        mon_a = addr_q.pop_front();
        check("rdw_addr", bus.rdw_addr, mon_a.w);
        check("rdd_addr", bus.rdd_addr, mon_a.d);
      end
    end
    if (bus.quant_clr)   take_ev(E_QCLR);
    if (bus.acc_clr)     take_ev(E_ACLR);
    if (bus.acc_sh)      take_ev(E_ASH);
    if (bus.quant_start) take_ev(E_QSTART);
    if (bus.done) begin
      done_cnt++;
      take_ev(E_DONE);
    end
  end

  // edge on which issue n (1-based) lands; the stall withholds edges k+2..k+4
  function automatic int iss(input int k, input int n, input bit stall);
    return (n == 1 || !stall) ? k + n : k + n + 3;
  endfunction

  function automatic longint all_outs();
    return {bus.rdw_addr, bus.rdd_en, bus.rdd_addr, bus.acc_clr, bus.acc_sh,
            bus.quant_clr, bus.quant_start, bus.busy, bus.done};
  endfunction

  task automatic start_job(input int wb, input int ws, input int wl,
                           input int ib, input int ist, input int il,
                           input int cd, output int k);
    @(posedge clk); #1;
    bus.wbaseaddr = wb;  bus.wstride_0 = ws;  bus.wlength_0 = wl;
    bus.ibaseaddr = ib;  bus.istride_0 = ist; bus.ilength_0 = il;
    bus.countdown = BCNTDWN'(cd);
    bus.start     = 1'b1;
    k = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_walk(input int k, input bit stall);
    int wa[7] = '{10, 12, 14, 10, 12, 14, 10};
    int da[7] = '{100, 100, 100, 105, 105, 105, 100};
    int dn;
    for (int i = 0; i < 7; i++) addr_q.push_back(addr_t'{wa[i], da[i]});
    dn = k + 7 + RDLAT + PIPE - 1 + (stall ? 3 : 0);
    ev_q.push_back(ev_t'{E_QCLR,   k});
    ev_q.push_back(ev_t'{E_ACLR,   iss(k, 1, stall) + RDLAT - 1});
    ev_q.push_back(ev_t'{E_ASH,    iss(k, 4, stall) + RDLAT - 1});
    ev_q.push_back(ev_t'{E_ASH,    iss(k, 7, stall) + RDLAT - 1});
    ev_q.push_back(ev_t'{E_QSTART, dn});
    ev_q.push_back(ev_t'{E_DONE,   dn});
  endtask

  task automatic run_job(input int k, input bit stall, input bit meddle);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 200) begin
      bus.rdd_grnt = !(stall && cyc >= k + 1 && cyc <= k + 3);
      if (meddle) begin
        bus.wbaseaddr = $urandom; bus.wstride_0 = $urandom;
        bus.ibaseaddr = $urandom; bus.istride_0 = $urandom;
        bus.wlength_0 = $urandom_range(0, 5);
        bus.ilength_0 = $urandom_range(0, 5);
        bus.countdown = BCNTDWN'($urandom_range(1, 20));
        bus.start     = (cyc == k + 2);
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start    = 1'b0;
    bus.rdd_grnt = 1'b1;
    check("job_done_seen", done_cnt - d0, 1);
    @(posedge clk); #1;
    check("busy_after_done", bus.busy, 0);
    check("issues_drained", addr_q.size(), 0);
    check("events_drained", ev_q.size(), 0);
    addr_q.delete();
    ev_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    bus.start = 1'b0; bus.rdd_grnt = 1'b1; bus.countdown = '0;
    bus.wbaseaddr = 0; bus.ibaseaddr = 0; bus.wstride_0 = 0;
    bus.istride_0 = 0; bus.wlength_0 = 0; bus.ilength_0 = 0;

    // reset state
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", all_outs(), 0);

    // basic walk, grant tied high
    start_job(10, 2, 2, 100, 5, 1, 7, k);
    check("start_busy", bus.busy, 1);
    check("start_rdd_en", bus.rdd_en, 1);
    push_walk(k, 1'b0);
    run_job(k, 1'b0, 1'b0);

    // same walk with grant withheld for three cycles
    start_job(10, 2, 2, 100, 5, 1, 7, k);
    push_walk(k, 1'b1);
    run_job(k, 1'b1, 1'b0);

    // data address wraps modulo 2^15; inner walker wraps every issue
    start_job(0, 1, 0, 'h7FFE, 3, 100, 3, k);
    addr_q.push_back(addr_t'{0, 'h7FFE});
    addr_q.push_back(addr_t'{0, 'h0001});
    addr_q.push_back(addr_t'{0, 'h0004});
    ev_q.push_back(ev_t'{E_QCLR,   k});
    ev_q.push_back(ev_t'{E_ACLR,   k + RDLAT});
    ev_q.push_back(ev_t'{E_ASH,    k + 2 + RDLAT - 1});
    ev_q.push_back(ev_t'{E_ASH,    k + 3 + RDLAT - 1});
    ev_q.push_back(ev_t'{E_QSTART, k + 3 + RDLAT + PIPE - 1});
    ev_q.push_back(ev_t'{E_DONE,   k + 3 + RDLAT + PIPE - 1});
    run_job(k, 1'b0, 1'b0);

    // empty job: done only, in the cycle after start
    start_job(10, 2, 2, 100, 5, 1, 0, k);
    check("cd0_busy", bus.busy, 0);
    ev_q.push_back(ev_t'{E_DONE, k});
    run_job(k, 1'b0, 1'b0);

    // start and config churn while busy must not disturb the job
    start_job(10, 2, 2, 100, 5, 1, 7, k);
    push_walk(k, 1'b0);
    run_job(k, 1'b0, 1'b1);

    // reset in the middle of a 10-issue job
    start_job(10, 2, 2, 100, 5, 1, 10, k);
    push_walk(k, 1'b0);
    ev_q.delete();
    addr_q.push_back(addr_t'{12, 100});
    addr_q.push_back(addr_t'{14, 100});
    addr_q.push_back(addr_t'{10, 105});
    ev_q.push_back(ev_t'{E_QCLR, k});
    ev_q.push_back(ev_t'{E_ACLR, k + RDLAT});
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    check("reset_issues_left", addr_q.size(), 7);
    check("reset_events_left", ev_q.size(), 0);
    addr_q.delete();
    ev_q.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    check("no_done_after_reset", done_cnt - d0, 0);
    check("idle_after_reset", all_outs(), 0);

    // fresh job after reset starts from the bases
    start_job(10, 2, 2, 100, 5, 1, 7, k);
    push_walk(k, 1'b0);
    run_job(k, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
